div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider for DIV/DIVU in the EX stage.
- Produces the stall_divE request consumed by the pipeline hazard logic, and obeys that logic's exception flush (annul).
- Result goes to the HI/LO write path: {HI = remainder, LO = quotient}.
- One operation in flight; operands are latched at launch.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH bits.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  EX holds a DIV/DIVU; held high while EX is stalled.
- signed_div  input  1  1 = DIV (signed), 0 = DIVU; sampled with start in IDLE.
- opdata1  input  WIDTH  dividend (rs).
- opdata2  input  WIDTH  divisor (rt).
- annul  input  1  exception flush (except_typeM != 0); cancels the operation.
- result  output  2*WIDTH  {remainder, quotient}.
- ready  output  1  one-cycle pulse; result valid this cycle.
- stall_div  output  1  combinational stall request to hazard logic.

Behaviour:
- States: IDLE, DIVZERO, ON, DONE; 2-bit state register; iteration counter is clog2(WIDTH)+1 bits.
- Reset (rst=1 at edge): state=IDLE, counter=0, result=0, ready=0; working registers cleared.
- IDLE:
  - start=1, annul=0, opdata2=0 -> DIVZERO.
  - start=1, annul=0, opdata2!=0 -> ON. Latch |opdata1| and |opdata2| (two's-complement abs when signed_div=1, raw when 0), the sign flags and signed_div; counter=0.
  - Otherwise stay in IDLE.
- DIVZERO: next state DONE with the result register loaded to 0. Divide by zero is UNPREDICTABLE in MIPS; the team defines the result as all zeros.
- ON: one restoring step per cycle.
  - Shift {rem,quo} left 1; trial = rem_hi - divisor; if trial is non-negative, rem_hi=trial and the quotient LSB = 1, else the LSB = 0.
  - counter increments each step; after the WIDTH-th step, go to DONE.
- Entering DONE from ON (final fix-up):
  - Signed, operand signs differ: negate the quotient.
  - Signed, dividend negative: negate the remainder.
  - Load result = {rem, quo}.
- DONE: ready=1 for exactly this cycle. Next state IDLE unconditionally; result holds until the next DONE load or reset.
- Latency, measured from the first IDLE cycle with start=1 (cycle 0):
  - Normal: ON in cycles 1..WIDTH, ready in cycle WIDTH+1 (33 at default).
  - Divide by zero: ready in cycle 2.
- stall_div = start & ~annul & (state != DONE). This is high from cycle 0 up to the cycle before ready, and low in the ready cycle so EX advances with the result.
- Back-to-back DIVs: the second DIV arrives in EX the cycle after DONE. FSM is then in IDLE, sees start and launches normally. A still-asserted start during DONE never relaunches.
- annul=1 in any state: next state IDLE, counter cleared, ready=0 next cycle, result unchanged. stall_div is forced low in the same cycle. annul overrides start.
- Operand inputs changing during ON/DIVZERO are ignored. start dropping mid-operation without annul does not abort; ready still fires (hazard logic never does this).
- rst mid-operation takes priority over everything: next cycle IDLE with all outputs 0.
- Most negative dividend / -1 (0x80000000 / 0xFFFFFFFF) gives quotient 0x80000000, remainder 0; wrap is permitted.

Test Plan:
- DIVU 100/7, start held: stall_div high cycles 0..32; ready in cycle 33 only; result = {0x00000002, 0x0000000E}.
- DIV 0xFFFFFFF9 (-7) / 2: ready cycle 33; quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Then DIV 7 / 0xFFFFFFFE: quotient 0xFFFFFFFD, remainder 0x00000001.
- DIVU 5/0: stall_div high cycles 0..1; ready in cycle 2; result = 0.
- DIVU 1000/3, annul pulsed in cycle 10: stall_div low in cycle 10; IDLE in cycle 11; no ready; result keeps its prior value. A new start in cycle 11 then completes correctly (ready in cycle 11+33).
- Back-to-back: DIVU 9/2 then DIV 0x80000000/0xFFFFFFFF with start continuously high. Two ready pulses 34 cycles apart; results {1,4} then {0, 0x80000000}.
- rst asserted in cycle 15 of an operation: next cycle state=IDLE, ready=0, result=0, stall_div follows start.

Source files
------------

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in EX.
// Result is {HI = remainder, LO = quotient}; one operation in flight, operands latched at launch.
//
// state   | meaning
// IDLE    | waiting for start; latches operands on launch
// DIVZERO | divisor was zero; result forced to 0
// ON      | one restoring step per cycle, WIDTH steps
// DONE    | ready pulse; result valid this cycle
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_div,
    input  logic [WIDTH-1:0]     opdata1,
    input  logic [WIDTH-1:0]     opdata2,
    input  logic                 annul,
    output logic [2*WIDTH-1:0]   result,
    output logic                 ready,
    output logic                 stall_div
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIVZERO = 2'd1,
        ON      = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] divisor;
    logic             neg_quo;
    logic             neg_rem;

    logic [WIDTH-1:0] abs1;
    logic [WIDTH-1:0] abs2;
    logic [WIDTH:0]   partial;
    logic             step_ok;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;
    logic [WIDTH-1:0] fix_rem;
    logic [WIDTH-1:0] fix_quo;
    logic             last_step;

    // Operand magnitudes; the most negative value maps onto itself, which is
    // the correct unsigned magnitude.
    always_comb begin
        abs1 = opdata1;
        abs2 = opdata2;
        if (signed_div && opdata1[WIDTH-1]) abs1 = -opdata1;
        if (signed_div && opdata2[WIDTH-1]) abs2 = -opdata2;
    end

    // partial < 2*divisor, so when the trial subtraction succeeds the new
    // remainder fits in WIDTH bits and the low-bit modular difference is exact.
    always_comb begin
        partial   = {rem, quo[WIDTH-1]};
        step_ok   = (partial >= {1'b0, divisor});
        step_rem  = step_ok ? (partial[WIDTH-1:0] - divisor) : partial[WIDTH-1:0];
        step_quo  = {quo[WIDTH-2:0], step_ok};
        fix_quo   = neg_quo ? -step_quo : step_quo;
        fix_rem   = neg_rem ? -step_rem : step_rem;
        last_step = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        stall_div  = start & ~annul & (state != DONE);
        if (annul) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) state_next = (opdata2 == '0) ? DIVZERO : ON;
                end
                DIVZERO: state_next = DONE;
                ON: begin
                    if (last_step) state_next = DONE;
                end
                DONE: state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
        if (state == DONE) ready = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            rem     <= '0;
            quo     <= '0;
            divisor <= '0;
            neg_quo <= 1'b0;
            neg_rem <= 1'b0;
            result  <= '0;
        end else if (annul) begin
            cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && (opdata2 != '0)) begin
                        rem     <= '0;
                        quo     <= abs1;
                        divisor <= abs2;
                        neg_quo <= signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
                        neg_rem <= signed_div & opdata1[WIDTH-1];
                        cnt     <= '0;
                    end
                end
                DIVZERO: begin
                    result <= '0;
                end
                ON: begin
                    rem <= step_rem;
                    quo <= step_quo;
                    cnt <= cnt + CW'(1);
                    if (last_step) result <= {fix_rem, fix_quo};
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, stall/ready timing, signed fix-up,
// divide by zero, annul, back-to-back launch and mid-operation reset.
module tb_div_unit;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           signed_div;
    logic [W-1:0]   opdata1;
    logic [W-1:0]   opdata2;
    logic           annul;
    logic [2*W-1:0] result;
    logic           ready;
    logic           stall_div;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    div_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .annul      (annul),
        .result     (result),
        .ready      (ready),
        .stall_div  (stall_div)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Caller has start=1 and operands driven at the start of cycle 0.
    // Operands are scrambled after launch to confirm they are ignored.
    task automatic op_run(input string tag, input int rdy,
                          input logic [63:0] exp_res, input logic [63:0] prior);
        for (int c = 0; c <= rdy; c++) begin
            if (c > 0) next_cycle();
            if (c == 1) begin
                opdata1    = ~opdata1;
                opdata2    = '0;
                signed_div = ~signed_div;
            end
            @(negedge clk);
            chk($sformatf("%s stall c%0d", tag, c), 64'(stall_div), 64'(c != rdy));
            chk($sformatf("%s ready c%0d", tag, c), 64'(ready), 64'(c == rdy));
            chk($sformatf("%s result c%0d", tag, c), result, (c == rdy) ? exp_res : prior);
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        signed_div = 1'b0;
        opdata1    = '0;
        opdata2    = '0;
        annul      = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("reset result", result, 64'h0);
        chk("reset ready", 64'(ready), 64'h0);
        chk("reset stall", 64'(stall_div), 64'h0);
        next_cycle();
        rst = 1'b0;
        next_cycle();

        // DIVU 100 / 7
        signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7; start = 1'b1;
        op_run("divu100_7", 33, {32'h2, 32'hE}, 64'h0);
        next_cycle();
        start = 1'b0;
        @(negedge clk);
        chk("divu100_7 after ready", 64'(ready), 64'h0);
        chk("divu100_7 after stall", 64'(stall_div), 64'h0);
        chk("divu100_7 hold", result, {32'h2, 32'hE});
        next_cycle();

        // DIV -7 / 2
        signed_div = 1'b1; opdata1 = 32'hFFFF_FFF9; opdata2 = 32'd2; start = 1'b1;
        op_run("div_m7_2", 33, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, {32'h2, 32'hE});
        next_cycle();
        start = 1'b0;
        next_cycle();

        // DIV 7 / -2
        signed_div = 1'b1; opdata1 = 32'd7; opdata2 = 32'hFFFF_FFFE; start = 1'b1;
        op_run("div_7_m2", 33, {32'h1, 32'hFFFF_FFFD}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        next_cycle();
        start = 1'b0;
        next_cycle();

        // DIVU 1000 / 3 annulled in cycle 10, relaunched in cycle 11
        signed_div = 1'b0; opdata1 = 32'd1000; opdata2 = 32'd3; start = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            if (c > 0) next_cycle();
            if (c == 10) annul = 1'b1;
            @(negedge clk);
            chk($sformatf("annul stall c%0d", c), 64'(stall_div), 64'(c != 10));
            chk($sformatf("annul ready c%0d", c), 64'(ready), 64'h0);
            chk($sformatf("annul result c%0d", c), result, {32'h1, 32'hFFFF_FFFD});
        end
        next_cycle();
        annul = 1'b0;
        op_run("divu1000_3", 33, {32'h1, 32'h14D}, {32'h1, 32'hFFFF_FFFD});
        next_cycle();
        start = 1'b0;
        next_cycle();

        // DIVU 5 / 0
        signed_div = 1'b0; opdata1 = 32'd5; opdata2 = 32'd0; start = 1'b1;
        op_run("divu5_0", 2, 64'h0, {32'h1, 32'h14D});
        next_cycle();
        start = 1'b0;
        next_cycle();

        // Back-to-back: DIVU 9/2 then DIV 0x80000000 / -1, start held throughout
        signed_div = 1'b0; opdata1 = 32'd9; opdata2 = 32'd2; start = 1'b1;
        op_run("b2b_first", 33, {32'h1, 32'h4}, 64'h0);
        next_cycle();
        signed_div = 1'b1; opdata1 = 32'h8000_0000; opdata2 = 32'hFFFF_FFFF;
        op_run("b2b_second", 33, {32'h0, 32'h8000_0000}, {32'h1, 32'h4});
        next_cycle();
        start = 1'b0;
        @(negedge clk);
        chk("b2b after ready", 64'(ready), 64'h0);
        next_cycle();

        // Reset asserted in cycle 15 of a DIVU 100 / 7
        signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7; start = 1'b1;
        for (int c = 0; c <= 15; c++) begin
            if (c > 0) next_cycle();
            if (c == 15) rst = 1'b1;
            @(negedge clk);
            chk($sformatf("rst ready c%0d", c), 64'(ready), 64'h0);
            chk($sformatf("rst result c%0d", c), result, {32'h0, 32'h8000_0000});
        end
        next_cycle();
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("post-rst ready", 64'(ready), 64'h0);
        chk("post-rst result", result, 64'h0);
        chk("post-rst stall", 64'(stall_div), 64'h0);
        next_cycle();
        opdata1 = 32'd100; opdata2 = 32'd7; signed_div = 1'b0; start = 1'b1;
        op_run("post-rst divu", 33, {32'h2, 32'hE}, 64'h0);
        next_cycle();
        start = 1'b0;
        @(negedge clk);
        chk("final ready", 64'(ready), 64'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
